// File: rtl/wishbone_master_if_pkg.sv
// Shared types and constants for the Wishbone classic single-cycle master.
// State encoding, default watchdog limit and watchdog counter sizing.
package wishbone_master_if_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUSY = 2'd1,
        WB_DONE = 2'd2
    } wb_state_t;

    localparam int WB_TMO_DEFAULT = 255;

    // A disabled watchdog still needs a legal one-bit counter width.
    function automatic int wdog_width(input int tmo);
        return (tmo > 0) ? $clog2(tmo + 1) : 1;
    endfunction

endpackage

// File: rtl/wishbone_master_if_if.sv
// CPU-port and Wishbone-bus signal bundle for one master instance.
// The master modport is the bridge; the slave modport is the CPU/bus side.
interface wishbone_master_if_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6
);
    localparam int SEL_W = DATA_W / 8;

    logic [STALL_W-1:0] stall_i;
    logic               flush_i;
    logic               cpu_ce_i;
    logic [ADDR_W-1:0]  cpu_addr_i;
    logic [DATA_W-1:0]  cpu_data_i;
    logic               cpu_we_i;
    logic [SEL_W-1:0]   cpu_sel_i;
    logic [DATA_W-1:0]  cpu_data_o;
    logic               cpu_err_o;
    logic               stallreq;
    logic [ADDR_W-1:0]  wishbone_addr_o;
    logic [DATA_W-1:0]  wishbone_data_o;
    logic               wishbone_we_o;
    logic [SEL_W-1:0]   wishbone_sel_o;
    logic               wishbone_stb_o;
    logic               wishbone_cyc_o;
    logic [DATA_W-1:0]  wishbone_data_i;
    logic               wishbone_ack_i;
    logic               wishbone_err_i;

    modport master (
        input  stall_i, flush_i, cpu_ce_i, cpu_addr_i, cpu_data_i, cpu_we_i, cpu_sel_i,
        input  wishbone_data_i, wishbone_ack_i, wishbone_err_i,
        output cpu_data_o, cpu_err_o, stallreq,
        output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
        output wishbone_stb_o, wishbone_cyc_o
    );

    modport slave (
        output stall_i, flush_i, cpu_ce_i, cpu_addr_i, cpu_data_i, cpu_we_i, cpu_sel_i,
        output wishbone_data_i, wishbone_ack_i, wishbone_err_i,
        input  cpu_data_o, cpu_err_o, stallreq,
        input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
        input  wishbone_stb_o, wishbone_cyc_o
    );

endinterface

// File: rtl/wishbone_master_if_wb_watchdog.sv
// Saturating BUSY-cycle counter; o_expired flags the last allowed cycle.
// TMO_CYC == 0 ties the output off and removes the counter.
module wb_watchdog
    import wishbone_master_if_pkg::*;
#(
    parameter int TMO_CYC = WB_TMO_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = wdog_width(TMO_CYC);

    generate
        if (TMO_CYC > 0) begin : g_on
            localparam logic [CW-1:0] LIMIT = CW'(TMO_CYC - 1);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (i_clr) begin
                    r_cnt <= '0;
                end else if (i_en && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign o_expired = i_en && (r_cnt == LIMIT);
        end else begin : g_off
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wishbone_master_if.sv
// Wishbone B4 classic single-cycle master for one CPU port; request latched at start.
// Request-to-data 2 cycles minimum; stallreq holds the CPU until DONE, DONE holds data while CTRL stalls.
module wishbone_master_if
    import wishbone_master_if_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6,
    parameter int TMO_CYC = WB_TMO_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    wishbone_master_if_if.master wb
);
    localparam int SEL_W = DATA_W / 8;

    wb_state_t         r_state;
    wb_state_t         w_next;
    logic              w_capture;
    logic              w_set_err;
    logic              w_load_ack;
    logic              w_in_busy;
    logic              w_expired;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_buf;
    logic              r_err;
    logic              r_cyc;

    assign w_in_busy = (r_state == WB_BUSY);

    wb_watchdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_capture),
        .i_en      (w_in_busy),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_set_err  = 1'b0;
        w_load_ack = 1'b0;
        unique case (r_state)
            WB_IDLE: begin
                if (wb.cpu_ce_i && !wb.flush_i) begin
                    w_next    = WB_BUSY;
                    w_capture = 1'b1;
                end
            end
            WB_BUSY: begin
                // Flush abandons the access; any later ack/err lands in IDLE and is ignored.
                if (wb.flush_i) begin
                    w_next = WB_IDLE;
                end else if (wb.wishbone_err_i) begin
                    w_next    = WB_DONE;
                    w_set_err = 1'b1;
                end else if (wb.wishbone_ack_i) begin
                    w_next     = WB_DONE;
                    w_load_ack = 1'b1;
                end else if (w_expired) begin
                    w_next    = WB_DONE;
                    w_set_err = 1'b1;
                end
            end
            WB_DONE: begin
                if (wb.flush_i || (wb.stall_i == '0)) begin
                    w_next = WB_IDLE;
                end
            end
            default: w_next = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_buf   <= '0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b0;
        end else begin
            r_cyc <= (w_next == WB_BUSY);
            if (w_capture) begin
                r_addr  <= wb.cpu_addr_i;
                r_wdata <= wb.cpu_we_i ? wb.cpu_data_i : '0;
                r_we    <= wb.cpu_we_i;
                r_sel   <= wb.cpu_sel_i;
                r_buf   <= '0;
                r_err   <= 1'b0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
                r_buf <= '0;
            end
            if (w_load_ack) begin
                r_buf <= r_we ? '0 : wb.wishbone_data_i;
            end
        end
    end

    assign wb.wishbone_addr_o = r_addr;
    assign wb.wishbone_data_o = r_wdata;
    assign wb.wishbone_we_o   = r_we;
    assign wb.wishbone_sel_o  = r_sel;
    assign wb.wishbone_cyc_o  = r_cyc;
    assign wb.wishbone_stb_o  = r_cyc;

    assign wb.cpu_data_o = (r_state == WB_DONE) ? r_buf : '0;
    assign wb.cpu_err_o  = (r_state == WB_DONE) && r_err;

    // Gated by rst so the stall request drops the instant reset asserts.
    assign wb.stallreq = !rst && (((r_state == WB_IDLE) && wb.cpu_ce_i && !wb.flush_i) || w_in_busy);

endmodule
